rs232_move_rx: RTL and testbench

//  RS232 receiver, 8N1, the inbound partner of the game's TxD link. A host PC sends ASCII move

---
 rtl/rs232_move_rx_if.sv | 23 ++
 rtl/rs232_move_rx.sv | 234 +++++++++++++++++++++++
 tb/tb_rs232_move_rx.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rs232_move_rx_if.sv
// Output bundle of the RS232 move receiver: received bytes, framing status and parsed
// move/pass commands. The receiver drives it through master; consumers attach as slave.
interface rs232_move_rx_if;
  logic [7:0] rx_byte;
  logic       rx_strobe;
  logic       frame_err;
  logic [2:0] move_x;
  logic [2:0] move_y;
  logic       move_valid;
  logic       pass_cmd;
  logic       parse_err;
  logic       busy;

  modport master (
    output rx_byte, rx_strobe, frame_err,
    output move_x, move_y, move_valid, pass_cmd, parse_err, busy
  );

  modport slave (
    input rx_byte, rx_strobe, frame_err,
    input move_x, move_y, move_valid, pass_cmd, parse_err, busy
  );
endinterface

// File: rtl/rs232_move_rx.sv
// 8N1 RS232 receiver plus ASCII move-command parser ("<col><row><CR|LF>" or "p<CR|LF>").
// Emits one-cycle move/pass/error strobes with board coordinates for the game controller.
module rs232_move_rx #(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 115200
) (
  input  logic            clk,
  input  logic            RST,
  input  logic            RxD,
  rs232_move_rx_if.master rx_if
);

  localparam int BIT_CNT = CLK_HZ / BAUD;
  localparam int HALF    = BIT_CNT / 2;
  localparam logic [8:0] BIT_LAST  = 9'(BIT_CNT - 1);
  localparam logic [8:0] HALF_LAST = 9'(HALF - 1);

  typedef enum logic [2:0] {
    R_IDLE,
    R_START,
    R_DATA,
    R_STOP,
    R_WAITHI
  } rx_state_t;

  typedef enum logic [1:0] {
    P_COL,
    P_ROW,
    P_END,
    P_PASS
  } p_state_t;

  logic       rxd_meta_q, rxd_s_q;
  rx_state_t  rstate_q, rstate_d;
  logic [8:0] cnt_q, cnt_d;
  logic [2:0] bidx_q, bidx_d;
  logic [7:0] shreg_q, shreg_d;
  logic [7:0] rx_byte_q, rx_byte_d;
  logic       rx_strobe_q, rx_strobe_d;
  logic       frame_err_q, frame_err_d;

  p_state_t   pstate_q, pstate_d;
  logic [2:0] x_tmp_q, x_tmp_d;
  logic [2:0] y_tmp_q, y_tmp_d;
  logic [2:0] move_x_q, move_x_d;
  logic [2:0] move_y_q, move_y_d;
  logic       move_valid_q, move_valid_d;
  logic       pass_cmd_q, pass_cmd_d;
  logic       parse_err_q, parse_err_d;

  logic       is_col, is_row, is_pass, is_term;

  // Two-flop synchroniser; idles high so reset does not look like a start bit.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      rxd_meta_q <= 1'b1;
      rxd_s_q    <= 1'b1;
    end else begin
      rxd_meta_q <= RxD;
      rxd_s_q    <= rxd_meta_q;
    end
  end

  // Receive FSM: the counter restarts every bit, so every sample lands mid-bit.
  always_comb begin
    rstate_d    = rstate_q;
    cnt_d       = cnt_q;
    bidx_d      = bidx_q;
    shreg_d     = shreg_q;
    rx_byte_d   = rx_byte_q;
    rx_strobe_d = 1'b0;
    frame_err_d = 1'b0;
    case (rstate_q)
      R_IDLE: begin
        if (!rxd_s_q) begin
          rstate_d = R_START;
          cnt_d    = '0;
        end
      end
      R_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d  = '0;
          bidx_d = '0;
          rstate_d = rxd_s_q ? R_IDLE : R_DATA;
        end else begin
          cnt_d = cnt_q + 9'd1;
        end
      end
      R_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shreg_d = {rxd_s_q, shreg_q[7:1]};
          if (bidx_q == 3'd7) begin
            rstate_d = R_STOP;
          end else begin
            bidx_d = bidx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 9'd1;
        end
      end
      R_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rxd_s_q) begin
            rx_byte_d   = shreg_q;
            rx_strobe_d = 1'b1;
            rstate_d    = R_IDLE;
          end else begin
            frame_err_d = 1'b1;
            rstate_d    = R_WAITHI;
          end
        end else begin
          cnt_d = cnt_q + 9'd1;
        end
      end
      R_WAITHI: begin
        if (rxd_s_q) rstate_d = R_IDLE;
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      rstate_q    <= R_IDLE;
      cnt_q       <= '0;
      bidx_q      <= '0;
      shreg_q     <= '0;
      rx_byte_q   <= '0;
      rx_strobe_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rstate_q    <= rstate_d;
      cnt_q       <= cnt_d;
      bidx_q      <= bidx_d;
      shreg_q     <= shreg_d;
      rx_byte_q   <= rx_byte_d;
      rx_strobe_q <= rx_strobe_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Character classes; letter case is folded for both column and pass commands.
  assign is_col  = ((rx_byte_q >= 8'h61) && (rx_byte_q <= 8'h68)) ||
                   ((rx_byte_q >= 8'h41) && (rx_byte_q <= 8'h48));
  assign is_row  = (rx_byte_q >= 8'h31) && (rx_byte_q <= 8'h38);
  assign is_pass = (rx_byte_q == 8'h70) || (rx_byte_q == 8'h50);
  assign is_term = (rx_byte_q == 8'h0D) || (rx_byte_q == 8'h0A);

  // Parser FSM: consumes one byte per rx_strobe; at most one command strobe per cycle.
  always_comb begin
    pstate_d     = pstate_q;
    x_tmp_d      = x_tmp_q;
    y_tmp_d      = y_tmp_q;
    move_x_d     = move_x_q;
    move_y_d     = move_y_q;
    move_valid_d = 1'b0;
    pass_cmd_d   = 1'b0;
    parse_err_d  = 1'b0;
    if (rx_strobe_q) begin
      case (pstate_q)
        P_COL: begin
          if (is_col) begin
            x_tmp_d  = rx_byte_q[2:0] - 3'd1;
            pstate_d = P_ROW;
          end else if (is_pass) begin
            pstate_d = P_PASS;
          end else if (!is_term) begin
            parse_err_d = 1'b1;
          end
        end
        P_ROW: begin
          if (is_row) begin
            y_tmp_d  = 3'(rx_byte_q - 8'h31);
            pstate_d = P_END;
          end else begin
            parse_err_d = 1'b1;
            pstate_d    = P_COL;
          end
        end
        P_END: begin
          if (is_term) begin
            move_x_d     = x_tmp_q;
            move_y_d     = y_tmp_q;
            move_valid_d = 1'b1;
          end else begin
            parse_err_d = 1'b1;
          end
          pstate_d = P_COL;
        end
        P_PASS: begin
          if (is_term) pass_cmd_d  = 1'b1;
          else         parse_err_d = 1'b1;
          pstate_d = P_COL;
        end
        default: pstate_d = P_COL;
      endcase
    end
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      pstate_q     <= P_COL;
      x_tmp_q      <= '0;
      y_tmp_q      <= '0;
      move_x_q     <= '0;
      move_y_q     <= '0;
      move_valid_q <= 1'b0;
      pass_cmd_q   <= 1'b0;
      parse_err_q  <= 1'b0;
    end else begin
      pstate_q     <= pstate_d;
      x_tmp_q      <= x_tmp_d;
      y_tmp_q      <= y_tmp_d;
      move_x_q     <= move_x_d;
      move_y_q     <= move_y_d;
      move_valid_q <= move_valid_d;
      pass_cmd_q   <= pass_cmd_d;
      parse_err_q  <= parse_err_d;
    end
  end

  assign rx_if.rx_byte    = rx_byte_q;
  assign rx_if.rx_strobe  = rx_strobe_q;
  assign rx_if.frame_err  = frame_err_q;
  assign rx_if.move_x     = move_x_q;
  assign rx_if.move_y     = move_y_q;
  assign rx_if.move_valid = move_valid_q;
  assign rx_if.pass_cmd   = pass_cmd_q;
  assign rx_if.parse_err  = parse_err_q;
  assign rx_if.busy       = (rstate_q != R_IDLE);

endmodule

// File: tb/tb_rs232_move_rx.sv
// Bench for rs232_move_rx: serial stimulus with a scoreboard of expected bytes and commands,
// run at a reduced bit period (16 clocks per bit) to keep the run short.
module tb_rs232_move_rx;

  localparam int CLK_HZ  = 50_000_000;
  localparam int BAUD    = 3_125_000;
  localparam int BIT_CNT = CLK_HZ / BAUD;

  localparam logic [1:0] K_MOVE = 2'd1;
  localparam logic [1:0] K_PASS = 2'd2;
  localparam logic [1:0] K_ERR  = 2'd3;

  logic clk = 1'b0;
  logic RST = 1'b0;
  logic RxD = 1'b1;

  rs232_move_rx_if rx_if ();

  rs232_move_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
    .clk   (clk),
    .RST   (RST),
    .RxD   (RxD),
    .rx_if (rx_if.master)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] byte_q [$];
  logic [7:0] cmd_q  [$];

  int strobe_cnt = 0;
  int frame_cnt  = 0;
  int mv_cycles  = 0;
  int busy_hi    = 0;
  logic mv_prev  = 1'b0;

  // Scoreboard monitor: every output event is matched against the next expected entry.
  always @(negedge clk) begin
    logic [7:0] exp_b, exp_c, obs_c;
    int nev;
    if (rx_if.busy) busy_hi++;
    if (rx_if.frame_err) frame_cnt++;
    if (rx_if.move_valid) mv_cycles++;
    if (rx_if.rx_strobe) begin
      strobe_cnt++;
      checks++;
      if (byte_q.size() == 0) begin
        errors++;
        $display("FAIL rx_byte_unexpected: got 0x%02h, expected no byte", rx_if.rx_byte);
      end else begin
        exp_b = byte_q.pop_front();
        if (rx_if.rx_byte !== exp_b) begin
          errors++;
          $display("FAIL rx_byte: got 0x%02h, expected 0x%02h", rx_if.rx_byte, exp_b);
        end
      end
    end
    nev = int'(rx_if.move_valid) + int'(rx_if.pass_cmd) + int'(rx_if.parse_err);
    if (nev != 0) begin
      checks++;
      if (nev > 1) begin
        errors++;
        $display("FAIL cmd_exclusive: %0d strobes high together, expected 1", nev);
      end
      if (rx_if.move_valid)     obs_c = {K_MOVE, rx_if.move_x, rx_if.move_y};
      else if (rx_if.pass_cmd)  obs_c = {K_PASS, 6'd0};
      else                      obs_c = {K_ERR, 6'd0};
      if (cmd_q.size() == 0) begin
        errors++;
        $display("FAIL cmd_unexpected: got kind=%0d x=%0d y=%0d, expected none",
                 obs_c[7:6], obs_c[5:3], obs_c[2:0]);
      end else begin
        exp_c = cmd_q.pop_front();
        if (obs_c !== exp_c) begin
          errors++;
          $display("FAIL cmd: got kind=%0d x=%0d y=%0d, expected kind=%0d x=%0d y=%0d",
                   obs_c[7:6], obs_c[5:3], obs_c[2:0], exp_c[7:6], exp_c[5:3], exp_c[2:0]);
        end
      end
    end
    if (mv_prev && rx_if.move_valid) begin
      checks++;
      errors++;
      $display("FAIL move_valid_width: high for 2+ cycles, expected 1");
    end
    mv_prev = rx_if.move_valid;
  end

  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(negedge clk);
    RxD = 1'b0;
    repeat (BIT_CNT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RxD = b[i];
      repeat (BIT_CNT) @(negedge clk);
    end
    RxD = stop;
    repeat (BIT_CNT) @(negedge clk);
  endtask

  task automatic send_good(input logic [7:0] b);
    byte_q.push_back(b);
    send_byte(b, 1'b1);
  endtask

  task automatic drain();
    int n = 0;
    while ((byte_q.size() != 0 || cmd_q.size() != 0) && n < 50 * BIT_CNT) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({rx_if.rx_byte, rx_if.rx_strobe, rx_if.frame_err, rx_if.move_x, rx_if.move_y,
         rx_if.move_valid, rx_if.pass_cmd, rx_if.parse_err, rx_if.busy} !== 22'd0) begin
      errors++;
      $display("FAIL reset_outputs: rx_byte=0x%02h busy=%b move=%0d,%0d, expected all 0",
               rx_if.rx_byte, rx_if.busy, rx_if.move_x, rx_if.move_y);
    end
    RST = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (rx_if.busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_busy: got %b, expected 0", rx_if.busy);
    end
  endtask

  task automatic test_move();
    int mv0 = mv_cycles;
    int s0  = strobe_cnt;
    cmd_q.push_back({K_MOVE, 3'd3, 3'd2});
    send_good(8'h64);
    send_good(8'h33);
    send_good(8'h0D);
    drain();
    checks++;
    if (byte_q.size() != 0 || cmd_q.size() != 0) begin
      errors++;
      $display("FAIL move_drain: %0d bytes %0d cmds pending, expected 0", byte_q.size(), cmd_q.size());
    end
    checks++;
    if (strobe_cnt - s0 != 3) begin
      errors++;
      $display("FAIL move_strobes: got %0d, expected 3", strobe_cnt - s0);
    end
    checks++;
    if (rx_if.rx_byte !== 8'h0D) begin
      errors++;
      $display("FAIL move_rx_byte_hold: got 0x%02h, expected 0x0d", rx_if.rx_byte);
    end
    checks++;
    if (rx_if.move_x !== 3'd3 || rx_if.move_y !== 3'd2) begin
      errors++;
      $display("FAIL move_hold: got x=%0d y=%0d, expected x=3 y=2", rx_if.move_x, rx_if.move_y);
    end
    checks++;
    if (mv_cycles - mv0 != 1) begin
      errors++;
      $display("FAIL move_valid_cycles: got %0d, expected 1", mv_cycles - mv0);
    end
  endtask

  task automatic test_pass();
    int s0 = strobe_cnt;
    cmd_q.push_back({K_PASS, 6'd0});
    send_good(8'h50);
    send_good(8'h0D);
    send_good(8'h0A);
    drain();
    checks++;
    if (byte_q.size() != 0 || cmd_q.size() != 0) begin
      errors++;
      $display("FAIL pass_drain: %0d bytes %0d cmds pending, expected 0", byte_q.size(), cmd_q.size());
    end
    checks++;
    if (strobe_cnt - s0 != 3) begin
      errors++;
      $display("FAIL pass_strobes: got %0d, expected 3", strobe_cnt - s0);
    end
  endtask

  task automatic test_parse_errors();
    cmd_q.push_back({K_ERR, 6'd0});
    send_good(8'h69);
    cmd_q.push_back({K_ERR, 6'd0});
    send_good(8'h61);
    send_good(8'h39);
    cmd_q.push_back({K_MOVE, 3'd7, 3'd7});
    send_good(8'h68);
    send_good(8'h38);
    send_good(8'h0D);
    drain();
    checks++;
    if (byte_q.size() != 0 || cmd_q.size() != 0) begin
      errors++;
      $display("FAIL perr_drain: %0d bytes %0d cmds pending, expected 0", byte_q.size(), cmd_q.size());
    end
    checks++;
    if (rx_if.move_x !== 3'd7 || rx_if.move_y !== 3'd7) begin
      errors++;
      $display("FAIL perr_move: got x=%0d y=%0d, expected x=7 y=7", rx_if.move_x, rx_if.move_y);
    end
  endtask

  task automatic test_frame_break();
    int s0 = strobe_cnt;
    int f0 = frame_cnt;
    int busy_low = 0;
    send_byte(8'h64, 1'b0);
    for (int i = 0; i < 20; i++) begin
      repeat (BIT_CNT) @(negedge clk);
      if (!rx_if.busy) busy_low++;
    end
    checks++;
    if (busy_low != 0) begin
      errors++;
      $display("FAIL break_busy: low at %0d samples, expected 0", busy_low);
    end
    RxD = 1'b1;
    repeat (2 * BIT_CNT) @(negedge clk);
    checks++;
    if (frame_cnt - f0 != 1 || strobe_cnt != s0) begin
      errors++;
      $display("FAIL frame_err: got %0d frame_err %0d strobes, expected 1 and 0",
               frame_cnt - f0, strobe_cnt - s0);
    end
    checks++;
    if (rx_if.busy !== 1'b0) begin
      errors++;
      $display("FAIL break_release_busy: got %b, expected 0", rx_if.busy);
    end
    cmd_q.push_back({K_MOVE, 3'd1, 3'd1});
    send_good(8'h62);
    send_good(8'h32);
    send_good(8'h0A);
    drain();
    checks++;
    if (byte_q.size() != 0 || cmd_q.size() != 0) begin
      errors++;
      $display("FAIL break_drain: %0d bytes %0d cmds pending, expected 0", byte_q.size(), cmd_q.size());
    end
  endtask

  task automatic test_glitch();
    int s0 = strobe_cnt;
    int f0 = frame_cnt;
    int b0;
    repeat (4) @(negedge clk);
    b0 = busy_hi;
    RxD = 1'b0;
    repeat (3) @(negedge clk);
    RxD = 1'b1;
    repeat (3 * BIT_CNT) @(negedge clk);
    checks++;
    if (busy_hi - b0 == 0) begin
      errors++;
      $display("FAIL glitch_busy: got 0 busy cycles, expected >0");
    end
    checks++;
    if (strobe_cnt != s0 || frame_cnt != f0 || rx_if.busy !== 1'b0) begin
      errors++;
      $display("FAIL glitch_quiet: strobes=%0d frame_errs=%0d busy=%b, expected 0 0 0",
               strobe_cnt - s0, frame_cnt - f0, rx_if.busy);
    end
  endtask

  task automatic test_reset_midbyte();
    logic [7:0] c = 8'h63;
    send_good(8'h61);
    drain();
    @(negedge clk);
    RxD = 1'b0;
    repeat (BIT_CNT) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      RxD = c[i];
      repeat (BIT_CNT) @(negedge clk);
    end
    RxD = c[4];
    repeat (BIT_CNT / 2) @(negedge clk);
    RST = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({rx_if.rx_byte, rx_if.rx_strobe, rx_if.frame_err, rx_if.move_x, rx_if.move_y,
         rx_if.move_valid, rx_if.pass_cmd, rx_if.parse_err, rx_if.busy} !== 22'd0) begin
      errors++;
      $display("FAIL midbyte_reset_outputs: rx_byte=0x%02h busy=%b move=%0d,%0d, expected all 0",
               rx_if.rx_byte, rx_if.busy, rx_if.move_x, rx_if.move_y);
    end
    RxD = 1'b1;
    repeat (2) @(negedge clk);
    RST = 1'b1;
    repeat (2 * BIT_CNT) @(negedge clk);
    cmd_q.push_back({K_MOVE, 3'd4, 3'd4});
    send_good(8'h65);
    send_good(8'h35);
    send_good(8'h0D);
    drain();
    checks++;
    if (byte_q.size() != 0 || cmd_q.size() != 0) begin
      errors++;
      $display("FAIL midbyte_drain: %0d bytes %0d cmds pending, expected 0", byte_q.size(), cmd_q.size());
    end
    checks++;
    if (rx_if.move_x !== 3'd4 || rx_if.move_y !== 3'd4) begin
      errors++;
      $display("FAIL midbyte_move: got x=%0d y=%0d, expected x=4 y=4", rx_if.move_x, rx_if.move_y);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_move();
    test_pass();
    test_parse_errors();
    test_frame_break();
    test_glitch();
    test_reset_midbyte();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
